// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encodings
// and default widths reused by the CPU top level and the memory model.
package mem_arb_defs;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D_BUSY = 2'd1,
    ST_I_BUSY = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
// The limit flag hands the next contested grant to the fetch port.
module arb_streak_counter
  import mem_arb_defs::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] streak_d, streak_q;

  always_comb begin
    streak_d = streak_q;
    if (clr_i) begin
      streak_d = '0;
    end else if (inc_i && (streak_q != LIMIT_VAL)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign limit_o = (streak_q == LIMIT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM data port,
// one request/ack transaction at a time, and freezes the pipeline while either waits.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: requesters hold req (and address/data) until their ready pulse;
  // the memory sees mem_req_o held with stable address/data until it returns mem_ack_i.

  arb_state_e        state_d, state_q;
  logic              if_ready_d, if_ready_q;
  logic              d_ready_d, d_ready_q;
  logic              mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0] if_data_d, if_data_q;
  logic [DATA_W-1:0] d_rdata_d, d_rdata_q;
  logic              streak_inc, streak_clr, streak_limit;
  logic              d_req;

  assign d_req = d_read_i | d_write_i;

  arb_streak_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_streak (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (streak_inc),
    .clr_i  (streak_clr),
    .limit_o(streak_limit)
  );

  always_comb begin
    state_d     = state_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    streak_inc  = 1'b0;
    streak_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data wins unless the fetch has already been passed over STARVE_LIMIT times.
        if (d_req && !(if_req_i && streak_limit)) begin
          state_d     = ST_D_BUSY;
          mem_we_d    = d_write_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          streak_inc  = if_req_i;
          streak_clr  = ~if_req_i;
        end else if (if_req_i) begin
          state_d    = ST_I_BUSY;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          streak_clr = 1'b1;
        end
      end
      ST_D_BUSY: begin
        if (mem_ack_i) begin
          if (!mem_we_q) d_rdata_d = mem_rdata_i;
          d_ready_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_I_BUSY: begin
        if (mem_ack_i) begin
          if_data_d  = mem_rdata_i;
          if_ready_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == ST_D_BUSY) || (state_q == ST_I_BUSY);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_data_o   = if_data_q;
  assign if_ready_o  = if_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign stall_o     = (if_req_i & ~if_ready_q) | (d_req & ~d_ready_q);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder with programmable
// ack delay, hand-computed expectations per cycle, and one summary line.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        d_read_i;
  logic        d_write_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic [1:0]  dbg_state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 0;
  logic [31:0] resp_data = 32'h0;
  int          busy_cnt = 0;

  mem_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ready_o (if_ready_o),
    .d_read_i   (d_read_i),
    .d_write_i  (d_write_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_ready_o  (d_ready_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .stall_o    (stall_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // memory responder: acks after ack_delay extra cycles of mem_req_o
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o) begin
        busy_cnt    = busy_cnt + 1;
        mem_ack_i   = (busy_cnt == ack_delay + 1);
        mem_rdata_i = resp_data;
      end else begin
        busy_cnt  = 0;
        mem_ack_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i  = 1'b0;
    d_read_i  = 1'b0;
    d_write_i = 1'b0;
  endtask

  logic [31:0] grants[6];
  int          n_grants;
  logic        prev_req;

  initial begin
    rst_i     = 1'b1;
    if_addr_i = 32'h0;
    d_addr_i  = 32'h0;
    d_wdata_i = 32'h0;
    idle_inputs();
    tick();
    tick();

    // reset state
    check("rst_state", 32'(dbg_state_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_if_data", if_data_o, 32'h0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    check("rst_readies", {30'h0, if_ready_o, d_ready_o}, 32'h0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // fetch only, zero-wait memory
    ack_delay = 0;
    resp_data = 32'h8C22_0004;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0010;
    #1;
    check("f_c0_stall", 32'(stall_o), 32'd1);
    tick();
    check("f_c1_req", 32'(mem_req_o), 32'd1);
    check("f_c1_addr", mem_addr_o, 32'h10);
    check("f_c1_we", 32'(mem_we_o), 32'd0);
    check("f_c1_stall", 32'(stall_o), 32'd1);
    tick();
    check("f_c2_ready", 32'(if_ready_o), 32'd1);
    check("f_c2_data", if_data_o, 32'h8C22_0004);
    check("f_c2_stall", 32'(stall_o), 32'd0);
    check("f_c2_req", 32'(mem_req_o), 32'd0);
    if_req_i = 1'b0;
    tick();
    check("f_c3_ready", 32'(if_ready_o), 32'd0);
    check("f_c3_data_held", if_data_o, 32'h8C22_0004);

    // simultaneous requests: data first, fetch granted in the IDLE after RESP
    resp_data = 32'h1111_2222;
    if_req_i  = 1'b1;
    if_addr_i = 32'h14;
    d_read_i  = 1'b1;
    d_addr_i  = 32'h100;
    tick();
    check("s_c1_addr", mem_addr_o, 32'h100);
    check("s_c1_we", 32'(mem_we_o), 32'd0);
    tick();
    check("s_c2_dready", 32'(d_ready_o), 32'd1);
    check("s_c2_iready", 32'(if_ready_o), 32'd0);
    check("s_c2_rdata", d_rdata_o, 32'h1111_2222);
    check("s_c2_stall", 32'(stall_o), 32'd1);
    d_read_i  = 1'b0;
    resp_data = 32'h3333_4444;
    tick();
    check("s_c3_idle", 32'(dbg_state_o), 32'd0);
    check("s_c3_req", 32'(mem_req_o), 32'd0);
    tick();
    check("s_c4_req", 32'(mem_req_o), 32'd1);
    check("s_c4_addr", mem_addr_o, 32'h14);
    tick();
    check("s_c5_iready", 32'(if_ready_o), 32'd1);
    check("s_c5_idata", if_data_o, 32'h3333_4444);
    check("s_c5_dready", 32'(d_ready_o), 32'd0);
    if_req_i = 1'b0;
    tick();

    // write with three wait states
    ack_delay = 3;
    resp_data = 32'h5A5A_5A5A;
    d_write_i = 1'b1;
    d_addr_i  = 32'h200;
    d_wdata_i = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("w_c%0d_req", c), 32'(mem_req_o), 32'd1);
      check($sformatf("w_c%0d_addr", c), mem_addr_o, 32'h200);
      check($sformatf("w_c%0d_wdata", c), mem_wdata_o, 32'hDEAD_BEEF);
      check($sformatf("w_c%0d_we", c), 32'(mem_we_o), 32'd1);
      check($sformatf("w_c%0d_dready", c), 32'(d_ready_o), 32'd0);
    end
    tick();
    check("w_c5_dready", 32'(d_ready_o), 32'd1);
    check("w_c5_rdata_kept", d_rdata_o, 32'h1111_2222);
    check("w_c5_req", 32'(mem_req_o), 32'd0);
    d_write_i = 1'b0;
    tick();
    check("w_c6_dready", 32'(d_ready_o), 32'd0);
    tick();

    // starvation guard: fetch held, data re-presented every IDLE
    ack_delay = 0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    d_read_i  = 1'b1;
    d_addr_i  = 32'h300;
    n_grants  = 0;
    prev_req  = 1'b0;
    for (int i = 0; i < 6; i++) grants[i] = 32'h0;
    for (int c = 0; c < 80 && n_grants < 6; c++) begin
      tick();
      if (mem_req_o && !prev_req) begin
        grants[n_grants] = mem_addr_o;
        n_grants = n_grants + 1;
      end
      prev_req = mem_req_o;
    end
    check("starve_grant_count", 32'(n_grants), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_grant%0d", i), grants[i], (i == 4) ? 32'h40 : 32'h300);
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    check("starve_back_idle", 32'(dbg_state_o), 32'd0);

    // reset in I_BUSY while the ack arrives
    resp_data = 32'h5555_AAAA;
    if_req_i  = 1'b1;
    if_addr_i = 32'h50;
    tick();
    check("r_c1_req", 32'(mem_req_o), 32'd1);
    rst_i    = 1'b1;
    if_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    check("r_c2_req", 32'(mem_req_o), 32'd0);
    check("r_c2_iready", 32'(if_ready_o), 32'd0);
    check("r_c2_state", 32'(dbg_state_o), 32'd0);
    check("r_c2_if_data", if_data_o, 32'h0);
    check("r_c2_d_rdata", d_rdata_o, 32'h0);
    check("r_c2_mem_addr", mem_addr_o, 32'h0);
    tick();
    check("r_c3_iready", 32'(if_ready_o), 32'd0);
    check("r_c3_req", 32'(mem_req_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
